// File: rtl/calc_pkg.sv
// Shared types and seven-segment helpers for the calculator result display.
package calc_pkg;

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}; codes above 9 cannot occur and show blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = 7'b1000000;
            4'd1:    bcd_to_seg = 7'b1111001;
            4'd2:    bcd_to_seg = 7'b0100100;
            4'd3:    bcd_to_seg = 7'b0110000;
            4'd4:    bcd_to_seg = 7'b0011001;
            4'd5:    bcd_to_seg = 7'b0010010;
            4'd6:    bcd_to_seg = 7'b0000010;
            4'd7:    bcd_to_seg = 7'b1111000;
            4'd8:    bcd_to_seg = 7'b0000000;
            4'd9:    bcd_to_seg = 7'b0010000;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/calc_result_display_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock, WIDTH steps per conversion.
module bin2bcd_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd
);
    localparam int CW = 4;

    logic [11:0]      bcd_q;
    logic [WIDTH-1:0] bin_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic [11:0]      adj;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++)
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    // done marks the cycle whose closing edge performs the final step
    assign done = busy_q && (cnt_q == CW'(WIDTH-1));
    assign busy = busy_q;
    assign bcd  = bcd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            bcd_q  <= '0;
            bin_q  <= bin;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            bcd_q  <= {adj[10:0], bin_q[WIDTH-1]};
            bin_q  <= {bin_q[WIDTH-2:0], 1'b0};
            cnt_q  <= cnt_q + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_result_display.sv
// Captures the ALU result on a load_n falling edge, converts to BCD and scans a
// 4-digit common-anode display. Optional sign display: CALC_SIGN_DISPLAY_EN.
module calc_result_display
    import calc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int REFRESH_BITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_n,
    input  logic [WIDTH-1:0] result,
    input  logic             neg,
    output logic             busy,
    output logic [11:0]      bcd,
    output logic [6:0]       seg,
    output logic [3:0]       an
);
    state_t                  state, state_nx;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    load_prev, load_evt, pending, start, latch_en;
    logic [WIDTH-1:0]        operand;
    logic                    conv_done, conv_busy_unused;
    logic [11:0]             conv_bcd, bcd_q;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              digit;
    logic [6:0]              dig3;

    // Synchroniser idles high so reset release never looks like a falling edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '1;
            load_prev <= 1'b1;
        end else begin
            sync_q    <= (sync_q << 1) | SYNC_STAGES'(load_n);
            load_prev <= sync_q[SYNC_STAGES-1];
        end
    end
    assign load_evt = load_prev & ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load_evt || pending) state_nx = CONV;
            CONV:    if (conv_done) state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start    = (state == IDLE) && (load_evt || pending);
        latch_en = (state == LATCH);
        busy     = (state != IDLE);
    end

    // One-deep queue for a load that arrives while a conversion is in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        pending <= 1'b0;
        else if (start)    pending <= pending && load_evt;
        else if (load_evt) pending <= 1'b1;
    end

`ifdef CALC_SIGN_DISPLAY_EN
    logic neg_cap, sign_q;
    assign operand = neg ? (~result + {{(WIDTH-1){1'b0}}, 1'b1}) : result;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_cap <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            if (start)    neg_cap <= neg;
            if (latch_en) sign_q  <= neg_cap;
        end
    end
    assign dig3 = sign_q ? SEG_MINUS : SEG_BLANK;
`else
    logic unused_neg;
    assign unused_neg = neg;
    assign operand    = result;
    assign dig3       = SEG_BLANK;
`endif

    bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (operand),
        .busy  (conv_busy_unused),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        bcd_q <= '0;
        else if (latch_en) bcd_q <= conv_bcd;
    end
    assign bcd = bcd_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) refresh_q <= '0;
        else        refresh_q <= refresh_q + 1'b1;
    end
    assign digit = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        an        = 4'b1111;
        an[digit] = 1'b0;
        seg       = SEG_BLANK;
        case (digit)
            2'd0: seg = bcd_to_seg(bcd_q[3:0]);
            2'd1: seg = (bcd_q[11:4] == 8'h00) ? SEG_BLANK : bcd_to_seg(bcd_q[7:4]);
            2'd2: seg = (bcd_q[11:8] == 4'h0)  ? SEG_BLANK : bcd_to_seg(bcd_q[11:8]);
            2'd3: seg = dig3;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display (short refresh counter for fast scans).
module tb_calc_result_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000, SB = 7'h7F, SM = 7'b0111111;

    typedef struct {
        logic [7:0]  res;
        logic        neg;
        logic [11:0] exp_bcd;
        logic [6:0]  d0, d1, d2, d3;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_n = 1'b1;
    logic [7:0]  result = '0;
    logic        neg = 1'b0;
    logic        busy;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_cmp = 0;
    int n_err = 0;

    calc_result_display #(.WIDTH(8), .SYNC_STAGES(2), .REFRESH_BITS(4)) dut (
        .clk(clk), .reset(reset), .load_n(load_n), .result(result), .neg(neg),
        .busy(busy), .bcd(bcd), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int t;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (busy === lvl) break;
        end
        if (t == 40) chk({name, "_timeout"}, 32'(busy), 32'(lvl));
    endtask

    // Starts a conversion and returns how many sampled cycles busy stayed high
    task automatic convert(input logic [7:0] r, input logic n, output int cycles);
        @(negedge clk);
        result = r; neg = n; load_n = 1'b0;
        wait_busy(1'b1, "busy_rise");
        load_n = 1'b0;
        load_n = 1'b1;
        cycles = 1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
        end
    endtask

    task automatic check_disp(input logic [6:0] e0, e1, e2, e3, input string name);
        logic [6:0] exp_seg [4];
        exp_seg = '{e0, e1, e2, e3};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk({name, "_onehot"}, 32'($countones(~an)), 32'd1);
            for (int d = 0; d < 4; d++)
                if (an[d] == 1'b0) chk($sformatf("%s_dig%0d", name, d), 32'(seg), 32'(exp_seg[d]));
        end
    endtask

    initial begin
        vec_t vecs [5];
        int   cyc;
        logic saw_busy;

        vecs[0] = '{8'd0,   1'b0, 12'h000, S0, SB, SB, SB};
        vecs[1] = '{8'd255, 1'b0, 12'h255, S5, S5, S2, SB};
        vecs[2] = '{8'd7,   1'b0, 12'h007, S7, SB, SB, SB};
`ifdef CALC_SIGN_DISPLAY_EN
        vecs[3] = '{8'hF6,  1'b1, 12'h010, S0, S1, SB, SM};
`else
        vecs[3] = '{8'hF6,  1'b1, 12'h246, S6, S4, S2, SB};
`endif
        vecs[4] = '{8'd100, 1'b0, 12'h100, S0, S0, S1, SB};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h000);
        chk("rst_an", 32'(an), 32'b1110);
        chk("rst_seg", 32'(seg), 32'(S0));
        reset = 1'b1;

        foreach (vecs[i]) begin
            convert(vecs[i].res, vecs[i].neg, cyc);
            chk($sformatf("v%0d_busy_cycles", i), 32'(cyc), 32'd9);
            chk($sformatf("v%0d_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
            check_disp(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, $sformatf("v%0d", i));
        end

        // Second load during busy queues behind the first conversion
        @(negedge clk);
        result = 8'd5; neg = 1'b0; load_n = 1'b0;
        wait_busy(1'b1, "pend_rise1");
        load_n = 1'b1;
        repeat (2) @(negedge clk);
        result = 8'd42; load_n = 1'b0;
        wait_busy(1'b0, "pend_fall1");
        chk("pend_first_bcd", 32'(bcd), 32'h005);
        wait_busy(1'b1, "pend_rise2");
        load_n = 1'b1;
        wait_busy(1'b0, "pend_fall2");
        chk("pend_second_bcd", 32'(bcd), 32'h042);
        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_busy |= busy;
        end
        chk("pend_no_third", 32'(saw_busy), 32'd0);

        // Reset in the middle of a conversion
        @(negedge clk);
        result = 8'd255; load_n = 1'b0;
        wait_busy(1'b1, "mid_rise");
        load_n = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcd", 32'(bcd), 32'h000);
        chk("mid_rst_an", 32'(an), 32'b1110);
        chk("mid_rst_seg", 32'(seg), 32'(S0));
        @(negedge clk);
        reset = 1'b1;
        saw_busy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_busy |= busy;
        end
        chk("post_rst_no_conv", 32'(saw_busy), 32'd0);
        chk("post_rst_bcd", 32'(bcd), 32'h000);
        check_disp(S0, SB, SB, SB, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
